// File: rtl/rambus_wb_responder_pkg.sv
// Shared definitions for the rambus Wishbone responder: bus defaults and FSM states.
package rambus_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int SEL_W_DEF  = DATA_W_DEF / 8;
    localparam int RAM_DEPTH  = 2 ** ADDR_W_DEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        RD_WAIT = 2'd2,
        ACK     = 2'd3
    } rb_state_e;
endpackage

// File: rtl/rambus_wb_responder_if.sv
// Wishbone B4 classic bundle for the rambus shared-RAM port.
interface rambus_wb_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();
    localparam int SEL_W = DATA_W / 8;

    logic              cyc;
    logic              stb;
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat_w;
    logic [DATA_W-1:0] dat_r;
    logic              ack;

    modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
    modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/rambus_wb_responder.sv
// Wishbone classic slave that turns each rambus cycle into one command on a
// 1RW synchronous SRAM port; one transaction in flight, all outputs registered.
module rambus_wb_responder
    import rambus_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int READ_LATENCY = 1,
    localparam int SEL_W       = DATA_W / 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    rambus_wb_responder_if.slave  rambus_wb,
    output logic                  ram_csb_o,
    output logic                  ram_web_o,
    output logic [SEL_W-1:0]      ram_wmask_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    output logic [DATA_W-1:0]     ram_din_o,
    input  logic [DATA_W-1:0]     ram_dout_i
);
    rb_state_e         state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic              csb_q, csb_d;
    logic              web_q, web_d;
    logic [SEL_W-1:0]  wmask_q, wmask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        ack_d   = 1'b0;
        dat_d   = dat_q;
        csb_d   = csb_q;
        web_d   = web_q;
        wmask_d = wmask_q;
        addr_d  = addr_q;
        din_d   = din_q;
        unique case (state_q)
            IDLE: begin
                if (rambus_wb.cyc && rambus_wb.stb) begin
                    addr_d  = rambus_wb.adr;
                    din_d   = rambus_wb.dat_w;
                    we_d    = rambus_wb.we;
                    web_d   = ~rambus_wb.we;
                    wmask_d = rambus_wb.we ? rambus_wb.sel : '0;
                    // An all-zero byte select writes nothing, so the SRAM stays
                    // deselected; CMD is still traversed to keep write latency uniform.
                    csb_d   = rambus_wb.we && (rambus_wb.sel == '0);
                    state_d = CMD;
                end
            end
            CMD: begin
                csb_d = 1'b1;
                web_d = 1'b1;
                if (!rambus_wb.cyc) begin
                    state_d = IDLE;
                end else if (we_q) begin
                    ack_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d   = 3'(READ_LATENCY);
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (!rambus_wb.cyc) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        dat_d   = ram_dout_i;
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                // The request is still on the bus here; it is only re-sampled in IDLE.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rambus_wb.ack   = ack_q;
    assign rambus_wb.dat_r = dat_q;
    assign ram_csb_o       = csb_q;
    assign ram_web_o       = web_q;
    assign ram_wmask_o     = wmask_q;
    assign ram_addr_o      = addr_q;
    assign ram_din_o       = din_q;
endmodule

// File: tb/tb_rambus_wb_responder.sv
// Directed bench for rambus_wb_responder with a behavioural 1RW SRAM model,
// exercising READ_LATENCY=1 and READ_LATENCY=3 instances.
module rambus_sram_model #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    localparam int SEL_W       = DATA_W / 8
) (
    input  logic              clk,
    input  logic              csb,
    input  logic              web,
    input  logic [SEL_W-1:0]  wmask,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] mem  [2**ADDR_W];
    logic [DATA_W-1:0] pipe [READ_LATENCY];
    int                cmd_cnt = 0;
    logic [SEL_W-1:0]  last_wmask = '0;

    always @(posedge clk) begin
        for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
        // Read data is only valid exactly READ_LATENCY cycles after the command.
        pipe[0] <= 'x;
        if (!csb) begin
            cmd_cnt <= cmd_cnt + 1;
            if (web) begin
                pipe[0] <= mem[addr];
            end else begin
                last_wmask <= wmask;
                for (int b = 0; b < SEL_W; b++)
                    if (wmask[b]) mem[addr][8*b +: 8] <= din[8*b +: 8];
            end
        end
    end

    assign dout = pipe[READ_LATENCY-1];
endmodule

module tb_rambus_wb_responder;
    import rambus_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rambus_wb_responder_if #(.ADDR_W(8), .DATA_W(32)) if1 ();
    rambus_wb_responder_if #(.ADDR_W(8), .DATA_W(32)) if3 ();

    logic        csb1, web1, csb3, web3;
    logic [3:0]  wmask1, wmask3;
    logic [7:0]  addr1, addr3;
    logic [31:0] din1, din3, dout1, dout3;

    rambus_wb_responder #(.ADDR_W(8), .DATA_W(32), .READ_LATENCY(1)) dut1 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .rambus_wb(if1),
        .ram_csb_o(csb1), .ram_web_o(web1), .ram_wmask_o(wmask1),
        .ram_addr_o(addr1), .ram_din_o(din1), .ram_dout_i(dout1));
    rambus_sram_model #(.ADDR_W(8), .DATA_W(32), .READ_LATENCY(1)) mdl1 (
        .clk(clk), .csb(csb1), .web(web1), .wmask(wmask1),
        .addr(addr1), .din(din1), .dout(dout1));

    rambus_wb_responder #(.ADDR_W(8), .DATA_W(32), .READ_LATENCY(3)) dut3 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .rambus_wb(if3),
        .ram_csb_o(csb3), .ram_web_o(web3), .ram_wmask_o(wmask3),
        .ram_addr_o(addr3), .ram_din_o(din3), .ram_dout_i(dout3));
    rambus_sram_model #(.ADDR_W(8), .DATA_W(32), .READ_LATENCY(3)) mdl3 (
        .clk(clk), .csb(csb3), .web(web3), .wmask(wmask3),
        .addr(addr3), .din(din3), .dout(dout3));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input bit cyc, input bit stb, input bit we,
                         input logic [3:0] sel, input logic [7:0] adr, input logic [31:0] dat);
        if (d == 0) begin
            if1.cyc = cyc; if1.stb = stb; if1.we = we; if1.sel = sel; if1.adr = adr; if1.dat_w = dat;
        end else begin
            if3.cyc = cyc; if3.stb = stb; if3.we = we; if3.sel = sel; if3.adr = adr; if3.dat_w = dat;
        end
    endtask

    function automatic logic get_ack(input int d);
        return (d == 0) ? if1.ack : if3.ack;
    endfunction

    function automatic logic [31:0] get_dat(input int d);
        return (d == 0) ? if1.dat_r : if3.dat_r;
    endfunction

    // Called #1 after a posedge: the request is visible from cycle 0.
    task automatic wait_ack(input int d, output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (get_ack(d)) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic txn(input int d, input string tag, input bit we, input logic [3:0] sel,
                       input logic [7:0] adr, input logic [31:0] dat, input int exp_lat);
        int lat;
        drive(d, 1'b1, 1'b1, we, sel, adr, dat);
        wait_ack(d, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        drive(d, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        @(posedge clk); #1;
        chk({tag, "_ack_once"}, 64'(get_ack(d)), 64'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ack"},   64'(if3.ack),   64'd0);
        chk({tag, "_dat"},   64'(if3.dat_r), 64'd0);
        chk({tag, "_csb"},   64'(csb3),      64'd1);
        chk({tag, "_web"},   64'(web3),      64'd1);
        chk({tag, "_wmask"}, 64'(wmask3),    64'd0);
        chk({tag, "_addr"},  64'(addr3),     64'd0);
        chk({tag, "_din"},   64'(din3),      64'd0);
    endtask

    initial begin
        int c0;
        int lat;
        int acks;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("rst");
        chk("rst_ack1",  64'(if1.ack), 64'd0);
        chk("rst_csb1",  64'(csb1),    64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: full write then read, RL=1
        c0 = mdl1.cmd_cnt;
        txn(0, "t1_wr", 1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 2);
        chk("t1_wr_cmds", 64'(mdl1.cmd_cnt - c0), 64'd1);
        txn(0, "t1_rd", 1'b0, 4'hF, 8'h10, 32'h0, 3);
        chk("t1_rd_dat", 64'(if1.dat_r), 64'hDEADBEEF);

        // 2: partial byte write merges into existing word
        txn(0, "t2_wr", 1'b1, 4'hF, 8'h20, 32'h11223344, 2);
        txn(0, "t2_wrb", 1'b1, 4'h2, 8'h20, 32'h0000AA00, 2);
        chk("t2_wmask", 64'(mdl1.last_wmask), 64'h2);
        txn(0, "t2_rd", 1'b0, 4'hF, 8'h20, 32'h0, 3);
        chk("t2_rd_dat", 64'(if1.dat_r), 64'h1122AA44);

        // 3: sel==0 write acks without touching the SRAM
        txn(0, "t3_pre", 1'b1, 4'hF, 8'h30, 32'h55555555, 2);
        c0 = mdl1.cmd_cnt;
        txn(0, "t3_wr0", 1'b1, 4'h0, 8'h30, 32'hFFFFFFFF, 2);
        chk("t3_no_cmd", 64'(mdl1.cmd_cnt - c0), 64'd0);
        chk("t3_dat_hold", 64'(if1.dat_r), 64'h1122AA44);
        txn(0, "t3_rd", 1'b0, 4'hF, 8'h30, 32'h0, 3);
        chk("t3_rd_dat", 64'(if1.dat_r), 64'h55555555);

        // 4: RL=3 read at top address, then an aborted read
        txn(1, "t4_wr", 1'b1, 4'hF, 8'hFF, 32'h0BADF00D, 2);
        txn(1, "t4_rd", 1'b0, 4'hF, 8'hFF, 32'h0, 5);
        chk("t4_rd_dat", 64'(if3.dat_r), 64'h0BADF00D);
        txn(1, "t4_wr2", 1'b1, 4'hF, 8'h40, 32'h12345678, 2);
        drive(1, 1'b1, 1'b1, 1'b0, 4'hF, 8'h40, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_in_rdwait", 64'(dut3.state_q), 64'(RD_WAIT));
        drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (if3.ack) acks++;
        end
        chk("t4_abort_noack", 64'(acks), 64'd0);
        chk("t4_abort_dat", 64'(if3.dat_r), 64'h0BADF00D);
        chk("t4_abort_idle", 64'(dut3.state_q), 64'(IDLE));
        txn(1, "t4_rd2", 1'b0, 4'hF, 8'h40, 32'h0, 5);
        chk("t4_rd2_dat", 64'(if3.dat_r), 64'h12345678);

        // 5: asynchronous reset in RD_WAIT takes effect before the next edge
        drive(1, 1'b1, 1'b1, 1'b0, 4'hF, 8'hFF, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("t5_rst");
        chk("t5_state", 64'(dut3.state_q), 64'(IDLE));
        drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        txn(1, "t5_rd", 1'b0, 4'hF, 8'hFF, 32'h0, 5);
        chk("t5_rd_dat", 64'(if3.dat_r), 64'h0BADF00D);

        // 6: back-to-back, request held through ACK then replaced by a read
        c0 = mdl1.cmd_cnt;
        drive(0, 1'b1, 1'b1, 1'b1, 4'hF, 8'h50, 32'hCAFEF00D);
        wait_ack(0, lat);
        chk("t6_wr_lat", 64'(lat), 64'd2);
        drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 8'h50, 32'h0);
        wait_ack(0, lat);
        chk("t6_rd_lat", 64'(lat), 64'd4);
        chk("t6_rd_dat", 64'(if1.dat_r), 64'hCAFEF00D);
        drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        @(posedge clk); #1;
        chk("t6_ack_once", 64'(if1.ack), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_cmds", 64'(mdl1.cmd_cnt - c0), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
